// File: rtl/phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : phase_scheduler
// Description : Intersection phase sequencer - approach selection from lane
//               queue loads, day/night green timing, pedestrian walk phases
//               and emergency-vehicle preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_scheduler #(
  parameter int DAY_GREEN   = 8,
  parameter int NIGHT_GREEN = 4,
  parameter int YELLOW_T    = 2,
  parameter int ALLRED_T    = 1,
  parameter int PED_T       = 6,
  parameter int EMG_MIN     = 5,
  parameter int MAX_SKIP    = 3,
  parameter int DAY_START   = 6,
  parameter int DAY_END     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  hoursIn,
  input  logic        pedSignal,
  input  logic        emgSignal,
  input  logic [7:0]  emgLane,
  input  logic [63:0] lanes,
  output logic [7:0]  greenOut,
  output logic [7:0]  yellowOut,
  output logic        walkOut,
  output logic [2:0]  phase,
  output logic [1:0]  servedDir,
  output logic [7:0]  countdown
);

  localparam int                 c_skipW      = $clog2(MAX_SKIP + 1);
  localparam logic [c_skipW-1:0] c_maxSkip    = c_skipW'(MAX_SKIP);
  localparam logic [7:0]         c_allredLoad = 8'(ALLRED_T - 1);
  localparam logic [7:0]         c_yellowLoad = 8'(YELLOW_T - 1);
  localparam logic [7:0]         c_pedLoad    = 8'(PED_T - 1);
  localparam logic [7:0]         c_emgLoad    = 8'(EMG_MIN - 1);
  localparam logic [7:0]         c_dayLoad    = 8'(DAY_GREEN - 1);
  localparam logic [7:0]         c_nightLoad  = 8'(NIGHT_GREEN - 1);
  localparam logic [4:0]         c_dayStart   = 5'(DAY_START);
  localparam logic [4:0]         c_dayEnd     = 5'(DAY_END);

  typedef enum logic [2:0] {
    ALLRED = 3'd0,
    GREEN  = 3'd1,
    YELLOW = 3'd2,
    PED    = 3'd3,
    EMG    = 3'd4
  } phaseT;

  phaseT              r_phase, w_phaseNext;
  logic [7:0]         r_countdown, w_countdownNext;
  logic [1:0]         r_servedDir, w_servedDirNext;
  logic [7:0]         r_green, w_greenNext;
  logic [7:0]         r_yellow, w_yellowNext;
  logic               r_walk, w_walkNext;
  logic               r_pedPending, w_pedPendingNext;
  logic               r_emgHold, w_emgHoldNext;
  logic [c_skipW-1:0] r_skip [4];
  logic [c_skipW-1:0] w_skipNext [4];
  logic               w_skipUpdate;

  logic [8:0]         w_load [4];
  logic               w_isDay;
  logic               w_emgActive;
  logic [1:0]         w_emgDir;
  logic [1:0]         w_rotIdx;
  logic               w_forceHit;
  logic [1:0]         w_forceDir;
  logic [8:0]         w_maxLoad;
  logic [1:0]         w_maxDir;
  logic [1:0]         w_selDir;

  // Both lanes of an approach sit in adjacent bits, W in the top pair.
  function automatic logic [7:0] laneMask(input logic [1:0] dir);
    return 8'b1100_0000 >> {dir, 1'b0};
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_approach
      assign w_load[gi] = {1'b0, lanes[63-16*gi -: 8]} + {1'b0, lanes[55-16*gi -: 8]};
      assign w_skipNext[gi] = (2'(gi) == w_selDir) ? '0 :
                              ((w_load[gi] != 9'd0) && (r_skip[gi] < c_maxSkip)) ? r_skip[gi] + 1'b1 :
                              r_skip[gi];
    end
  endgenerate

  assign w_isDay     = (hoursIn >= c_dayStart) && (hoursIn < c_dayEnd);
  assign w_emgActive = emgSignal && (emgLane != 8'd0);

  always_comb begin
    if (|emgLane[7:6])      w_emgDir = 2'd0;
    else if (|emgLane[5:4]) w_emgDir = 2'd1;
    else if (|emgLane[3:2]) w_emgDir = 2'd2;
    else                    w_emgDir = 2'd3;
  end

  // Walk the rotation starting after the last served approach; strict '>'
  // keeps ties (and the all-zero case) on the earliest candidate.
  always_comb begin
    w_rotIdx   = r_servedDir;
    w_forceHit = 1'b0;
    w_forceDir = r_servedDir + 2'd1;
    w_maxLoad  = '0;
    w_maxDir   = r_servedDir + 2'd1;
    for (int k = 1; k <= 4; k++) begin
      w_rotIdx = r_servedDir + 2'(k);
      if (!w_forceHit && (r_skip[w_rotIdx] >= c_maxSkip)) begin
        w_forceHit = 1'b1;
        w_forceDir = w_rotIdx;
      end
      if (w_load[w_rotIdx] > w_maxLoad) begin
        w_maxLoad = w_load[w_rotIdx];
        w_maxDir  = w_rotIdx;
      end
    end
    w_selDir = w_forceHit ? w_forceDir : w_maxDir;
  end

  always_comb begin
    w_phaseNext      = r_phase;
    w_countdownNext  = r_countdown - 8'd1;
    w_servedDirNext  = r_servedDir;
    w_greenNext      = r_green;
    w_yellowNext     = r_yellow;
    w_walkNext       = r_walk;
    w_pedPendingNext = r_pedPending | pedSignal;
    w_emgHoldNext    = 1'b0;
    w_skipUpdate     = 1'b0;
    case (r_phase)
      ALLRED: begin
        if (r_countdown == 8'd0) begin
          if (w_emgActive) begin
            w_phaseNext     = EMG;
            w_countdownNext = c_emgLoad;
            w_servedDirNext = w_emgDir;
            w_greenNext     = laneMask(w_emgDir);
          end else if (r_pedPending) begin
            w_phaseNext      = PED;
            w_countdownNext  = c_pedLoad;
            w_walkNext       = 1'b1;
            w_pedPendingNext = pedSignal;
          end else begin
            w_phaseNext     = GREEN;
            w_countdownNext = w_isDay ? c_dayLoad : c_nightLoad;
            w_servedDirNext = w_selDir;
            w_greenNext     = laneMask(w_selDir);
            w_skipUpdate    = 1'b1;
          end
        end
      end
      GREEN: begin
        if (w_emgActive && (w_emgDir == r_servedDir)) begin
          w_phaseNext     = EMG;
          w_countdownNext = c_emgLoad;
        end else if (w_emgActive || (r_countdown == 8'd0)) begin
          w_phaseNext     = YELLOW;
          w_countdownNext = c_yellowLoad;
          w_yellowNext    = r_green;
          w_greenNext     = 8'd0;
        end
      end
      YELLOW: begin
        if (r_countdown == 8'd0) begin
          w_phaseNext     = ALLRED;
          w_countdownNext = c_allredLoad;
          w_yellowNext    = 8'd0;
        end
      end
      PED: begin
        if (w_emgActive) begin
          w_phaseNext      = ALLRED;
          w_countdownNext  = c_allredLoad;
          w_walkNext       = 1'b0;
          w_pedPendingNext = 1'b1;
        end else if (r_countdown == 8'd0) begin
          w_phaseNext     = ALLRED;
          w_countdownNext = c_allredLoad;
          w_walkNext      = 1'b0;
        end
      end
      EMG: begin
        if ((w_emgActive && (w_emgDir != r_servedDir)) ||
            (!w_emgActive && (r_emgHold || (r_countdown == 8'd0)))) begin
          w_phaseNext     = YELLOW;
          w_countdownNext = c_yellowLoad;
          w_yellowNext    = r_green;
          w_greenNext     = 8'd0;
        end else begin
          // Minimum served: park the countdown at zero while the vehicle stays.
          w_countdownNext = (r_countdown == 8'd0) ? 8'd0 : r_countdown - 8'd1;
          w_emgHoldNext   = (r_countdown == 8'd0);
        end
      end
      default: begin
        w_phaseNext     = ALLRED;
        w_countdownNext = c_allredLoad;
        w_greenNext     = 8'd0;
        w_yellowNext    = 8'd0;
        w_walkNext      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase      <= ALLRED;
      r_countdown  <= c_allredLoad;
      r_servedDir  <= 2'd3;
      r_green      <= 8'd0;
      r_yellow     <= 8'd0;
      r_walk       <= 1'b0;
      r_pedPending <= 1'b0;
      r_emgHold    <= 1'b0;
      for (int i = 0; i < 4; i++) r_skip[i] <= '0;
    end else begin
      r_phase      <= w_phaseNext;
      r_countdown  <= w_countdownNext;
      r_servedDir  <= w_servedDirNext;
      r_green      <= w_greenNext;
      r_yellow     <= w_yellowNext;
      r_walk       <= w_walkNext;
      r_pedPending <= w_pedPendingNext;
      r_emgHold    <= w_emgHoldNext;
      if (w_skipUpdate) begin
        for (int i = 0; i < 4; i++) r_skip[i] <= w_skipNext[i];
      end
    end
  end

  assign greenOut  = r_green;
  assign yellowOut = r_yellow;
  assign walkOut   = r_walk;
  assign phase     = r_phase;
  assign servedDir = r_servedDir;
  assign countdown = r_countdown;

endmodule
`default_nettype wire

// File: tb/tb_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_phase_scheduler
// Description : Directed self-checking bench for phase_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_phase_scheduler;

  localparam logic [2:0] P_AR  = 3'd0;
  localparam logic [2:0] P_GR  = 3'd1;
  localparam logic [2:0] P_YE  = 3'd2;
  localparam logic [2:0] P_PED = 3'd3;
  localparam logic [2:0] P_EMG = 3'd4;
  localparam logic [7:0] M_W   = 8'hC0;
  localparam logic [7:0] M_S   = 8'h30;
  localparam logic [7:0] M_E   = 8'h0C;
  localparam logic [7:0] M_N   = 8'h03;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  hoursIn = 5'd12;
  logic        pedSignal = 1'b0;
  logic        emgSignal = 1'b0;
  logic [7:0]  emgLane = 8'd0;
  logic [63:0] lanes = 64'd0;
  logic [7:0]  greenOut;
  logic [7:0]  yellowOut;
  logic        walkOut;
  logic [2:0]  phase;
  logic [1:0]  servedDir;
  logic [7:0]  countdown;

  int passCount = 0;
  int checkCount = 0;
  int invViol = 0;

  phase_scheduler dut (
    .clk       (clk),
    .rst       (rst),
    .hoursIn   (hoursIn),
    .pedSignal (pedSignal),
    .emgSignal (emgSignal),
    .emgLane   (emgLane),
    .lanes     (lanes),
    .greenOut  (greenOut),
    .yellowOut (yellowOut),
    .walkOut   (walkOut),
    .phase     (phase),
    .servedDir (servedDir),
    .countdown (countdown)
  );

  always #5 clk = ~clk;

  logic [29:0] obs;
  assign obs = {phase, servedDir, greenOut, yellowOut, walkOut, countdown};

  logic [7:0] lit;
  logic [3:0] litDirs;
  assign lit     = greenOut | yellowOut;
  assign litDirs = {|lit[7:6], |lit[5:4], |lit[3:2], |lit[1:0]};

  always @(negedge clk) begin
    if (!rst) begin
      if (($countones(litDirs) > 1) || (walkOut && (lit != 8'd0))) invViol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [29:0] pk(input logic [2:0] ph, input logic [1:0] sd,
                                     input logic [7:0] g, input logic [7:0] y,
                                     input logic w, input logic [7:0] cd);
    return {ph, sd, g, y, w, cd};
  endfunction

  function automatic logic [7:0] dirMask(input int d);
    case (d)
      0: return M_W;
      1: return M_S;
      2: return M_E;
      default: return M_N;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [29:0] e;
    hoursIn = 5'd12;
    lanes = {8'd48, 8'd14, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    doReset();
    e = pk(P_AR, 2'd3, 8'd0, 8'd0, 1'b0, 8'd0);
    checkCount++;
    if (obs !== e) $display("FAIL reset: got %h expected %h", obs, e);
    else passCount++;
  endtask

  // Continues from test_reset: W wins by load, then W drains and S follows.
  task automatic test_day_sequence();
    logic [29:0] e [12];
    for (int i = 0; i < 8; i++) e[i] = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'(7 - i));
    e[8]  = pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd1);
    e[9]  = pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd0);
    e[10] = pk(P_AR, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    e[11] = pk(P_GR, 2'd1, M_S, 8'd0, 1'b0, 8'd7);
    for (int i = 0; i < 12; i++) begin
      tick();
      checkCount++;
      if (obs !== e[i]) $display("FAIL day_seq[%0d]: got %h expected %h", i, obs, e[i]);
      else passCount++;
      if (i == 3) lanes = {8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    end
  endtask

  task automatic test_night_rotation();
    logic [29:0] e [28];
    hoursIn = 5'd22;
    lanes = 64'd0;
    doReset();
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < 4; c++) e[d*7 + c] = pk(P_GR, 2'(d), dirMask(d), 8'd0, 1'b0, 8'(3 - c));
      e[d*7 + 4] = pk(P_YE, 2'(d), 8'd0, dirMask(d), 1'b0, 8'd1);
      e[d*7 + 5] = pk(P_YE, 2'(d), 8'd0, dirMask(d), 1'b0, 8'd0);
      e[d*7 + 6] = pk(P_AR, 2'(d), 8'd0, 8'd0, 1'b0, 8'd0);
    end
    for (int i = 0; i < 28; i++) begin
      tick();
      checkCount++;
      if (obs !== e[i]) $display("FAIL night_rot[%0d]: got %h expected %h", i, obs, e[i]);
      else passCount++;
    end
  endtask

  task automatic test_skip_force();
    int dirs [5] = '{3, 3, 3, 2, 3};
    logic [29:0] e;
    hoursIn = 5'd30;
    lanes = {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd255};
    doReset();
    for (int s = 0; s < 5; s++) begin
      if (s == 0) tick();
      else repeat (7) tick();
      e = pk(P_GR, 2'(dirs[s]), dirMask(dirs[s]), 8'd0, 1'b0, 8'd3);
      checkCount++;
      if (obs !== e) $display("FAIL skip_sel[%0d]: got %h expected %h", s, obs, e);
      else passCount++;
    end
  endtask

  task automatic test_ped();
    logic [29:0] e [14];
    hoursIn = 5'd20;
    lanes = {8'd5, 56'd0};
    doReset();
    tick();
    pedSignal = 1'b1;
    tick();
    pedSignal = 1'b0;
    checkCount++;
    if (obs !== pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd2))
      $display("FAIL ped_green: got %h expected %h", obs, pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd2));
    else passCount++;
    e[0] = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd1);
    e[1] = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd0);
    e[2] = pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd1);
    e[3] = pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd0);
    e[4] = pk(P_AR, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    for (int c = 0; c < 6; c++) e[5 + c] = pk(P_PED, 2'd0, 8'd0, 8'd0, 1'b1, 8'(5 - c));
    e[11] = pk(P_AR, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    e[12] = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd3);
    e[13] = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd2);
    for (int i = 0; i < 14; i++) begin
      tick();
      checkCount++;
      if (obs !== e[i]) $display("FAIL ped_seq[%0d]: got %h expected %h", i, obs, e[i]);
      else passCount++;
    end
  endtask

  task automatic test_emergency();
    logic [29:0] e [25];
    hoursIn = 5'd6;
    lanes = {8'd5, 56'd0};
    emgLane = 8'b0000_1000;
    doReset();
    repeat (3) tick();
    checkCount++;
    if (obs !== pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd5))
      $display("FAIL emg_pre: got %h expected %h", obs, pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd5));
    else passCount++;
    e[1] = pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd1);
    e[2] = pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd0);
    e[3] = pk(P_AR, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    for (int t = 4; t <= 20; t++) e[t] = pk(P_EMG, 2'd2, M_E, 8'd0, 1'b0, (t < 8) ? 8'(8 - t) : 8'd0);
    e[21] = pk(P_YE, 2'd2, 8'd0, M_E, 1'b0, 8'd1);
    e[22] = pk(P_YE, 2'd2, 8'd0, M_E, 1'b0, 8'd0);
    e[23] = pk(P_AR, 2'd2, 8'd0, 8'd0, 1'b0, 8'd0);
    e[24] = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd7);
    emgSignal = 1'b1;
    for (int t = 1; t <= 24; t++) begin
      tick();
      checkCount++;
      if (obs !== e[t]) $display("FAIL emg_seq[%0d]: got %h expected %h", t, obs, e[t]);
      else passCount++;
      if (t == 20) emgSignal = 1'b0;
    end
  endtask

  task automatic test_emg_same_approach();
    hoursIn = 5'd2;
    lanes = {8'd5, 56'd0};
    emgSignal = 1'b0;
    emgLane = 8'b0100_0000;
    doReset();
    tick();
    emgSignal = 1'b1;
    tick();
    emgSignal = 1'b0;
    checkCount++;
    if (obs !== pk(P_EMG, 2'd0, M_W, 8'd0, 1'b0, 8'd4))
      $display("FAIL emg_same: got %h expected %h", obs, pk(P_EMG, 2'd0, M_W, 8'd0, 1'b0, 8'd4));
    else passCount++;
    repeat (5) tick();
    checkCount++;
    if (obs !== pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd1))
      $display("FAIL emg_same_exit: got %h expected %h", obs, pk(P_YE, 2'd0, 8'd0, M_W, 1'b0, 8'd1));
    else passCount++;
  endtask

  task automatic test_ped_abort();
    logic [29:0] e;
    hoursIn = 5'd22;
    lanes = 64'd0;
    emgSignal = 1'b0;
    doReset();
    pedSignal = 1'b1;
    tick();
    pedSignal = 1'b0;
    repeat (7) tick();
    e = pk(P_PED, 2'd0, 8'd0, 8'd0, 1'b1, 8'd5);
    checkCount++;
    if (obs !== e) $display("FAIL ped_abort_entry: got %h expected %h", obs, e);
    else passCount++;
    emgSignal = 1'b1;
    emgLane = 8'b0011_0000;
    tick();
    e = pk(P_AR, 2'd0, 8'd0, 8'd0, 1'b0, 8'd0);
    checkCount++;
    if (obs !== e) $display("FAIL ped_abort_ar: got %h expected %h", obs, e);
    else passCount++;
    tick();
    emgSignal = 1'b0;
    e = pk(P_EMG, 2'd1, M_S, 8'd0, 1'b0, 8'd4);
    checkCount++;
    if (obs !== e) $display("FAIL ped_abort_emg: got %h expected %h", obs, e);
    else passCount++;
    repeat (8) tick();
    e = pk(P_PED, 2'd1, 8'd0, 8'd0, 1'b1, 8'd5);
    checkCount++;
    if (obs !== e) $display("FAIL ped_abort_reserve: got %h expected %h", obs, e);
    else passCount++;
  endtask

  task automatic test_async_reset();
    logic [29:0] e;
    hoursIn = 5'd22;
    lanes = 64'd0;
    emgSignal = 1'b1;
    emgLane = 8'b0000_0001;
    doReset();
    tick();
    e = pk(P_EMG, 2'd3, M_N, 8'd0, 1'b0, 8'd4);
    checkCount++;
    if (obs !== e) $display("FAIL areset_emg: got %h expected %h", obs, e);
    else passCount++;
    pedSignal = 1'b1;
    tick();
    pedSignal = 1'b0;
    rst = 1'b1;
    #1;
    e = pk(P_AR, 2'd3, 8'd0, 8'd0, 1'b0, 8'd0);
    checkCount++;
    if (obs !== e) $display("FAIL areset_immediate: got %h expected %h", obs, e);
    else passCount++;
    emgSignal = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checkCount++;
    if (obs !== e) $display("FAIL areset_held: got %h expected %h", obs, e);
    else passCount++;
    tick();
    e = pk(P_GR, 2'd0, M_W, 8'd0, 1'b0, 8'd3);
    checkCount++;
    if (obs !== e) $display("FAIL areset_resume: got %h expected %h", obs, e);
    else passCount++;
  endtask

  task automatic test_invariant();
    checkCount++;
    if (invViol !== 0) $display("FAIL invariant: got %0d violations expected 0", invViol);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_day_sequence();
    test_night_rotation();
    test_skip_force();
    test_ped();
    test_emergency();
    test_emg_same_approach();
    test_ped_abort();
    test_async_reset();
    test_invariant();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
`default_nettype wire
